// File: rtl/spi_reg_pkg.sv
// Shared command encodings and FSM state type for the SPI register master.
package spi_reg_pkg;

    localparam logic [1:0] CMD_RD   = 2'b00;
    localparam logic [1:0] CMD_RSVD = 2'b01;
    localparam logic [1:0] CMD_WR   = 2'b10;
    localparam logic [1:0] CMD_FAST = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SHIFT_HI,
        SHIFT_LO,
        WAIT_WR,
        HOLD,
        GAP
    } state_t;

    function automatic logic cmd_is_legal(input logic [1:0] op);
        return op != CMD_RSVD;
    endfunction

endpackage

// File: rtl/spi_tick_gen.sv
// Phase timer: pulses tick on the last cycle of every CLK_DIV-cycle phase and
// restarts from zero whenever the owning FSM changes state.
module spi_tick_gen #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic restart,
    output logic tick
);

    localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign tick = (cnt_q == CNT_W'(CLK_DIV - 1));

    always_comb begin
        cnt_d = cnt_q + CNT_W'(1);
        if (restart || tick) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/spi_reg_master.sv
// SPI mode-0 register master: one command byte {op, arg} then len data words.
// Define SPI_REG_MASTER_STATUS_EN to capture the slave byte returned during the command byte.
module spi_reg_master
    import spi_reg_pkg::*;
#(
    parameter int REG_W   = 8,
    parameter int CLK_DIV = 4,
    parameter int LEN_W   = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       cmd_op,
    input  logic [5:0]       cmd_arg,
    input  logic [LEN_W-1:0] len,
    output logic             busy,
    output logic             done,
    input  logic [REG_W-1:0] wr_data,
    input  logic             wr_valid,
    output logic             wr_ready,
    output logic [REG_W-1:0] rd_data,
    output logic             rd_vld,
    output logic [7:0]       status,
    output logic             status_vld,
    output logic             sclk,
    output logic             mosi,
    input  logic             miso,
    output logic             nss
);

    localparam int BIT_W = $clog2(REG_W);

    state_t           state_q, state_d;
    logic [1:0]       op_q, op_d;
    logic [LEN_W-1:0] word_cnt_q, word_cnt_d;
    logic [BIT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic             cmd_phase_q, cmd_phase_d;
    logic             gap_half_q, gap_half_d;
    logic [REG_W-1:0] tx_q, tx_d;
    logic [REG_W-1:0] rx_q, rx_d;
    logic [REG_W-1:0] rd_data_q, rd_data_d;
    logic             rd_vld_q, rd_vld_d;
    logic             wr_ready_q, wr_ready_d;
    logic             done_q, done_d;
    logic             sclk_q, sclk_d;
    logic             nss_q, nss_d;
    logic             miso_s1_q, miso_s1_d;
    logic             miso_s2_q, miso_s2_d;
    logic             tick;
    logic             last_bit;
    logic [REG_W-1:0] rx_word;

    spi_tick_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_tick (
        .clk     (clk),
        .rst     (rst),
        .restart (state_d != state_q),
        .tick    (tick)
    );

    assign last_bit = cmd_phase_q ? (bit_cnt_q == BIT_W'(7))
                                  : (bit_cnt_q == BIT_W'(REG_W - 1));
    // miso is taken at the end of the high phase so the two-flop synchroniser
    // delay still lands inside the window opened by the rising edge.
    assign rx_word  = {rx_q[REG_W-2:0], miso_s2_q};

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        word_cnt_d  = word_cnt_q;
        bit_cnt_d   = bit_cnt_q;
        cmd_phase_d = cmd_phase_q;
        gap_half_d  = gap_half_q;
        tx_d        = tx_q;
        rx_d        = rx_q;
        rd_data_d   = rd_data_q;
        rd_vld_d    = 1'b0;
        wr_ready_d  = 1'b0;
        done_d      = 1'b0;
        miso_s1_d   = miso;
        miso_s2_d   = miso_s1_q;

        case (state_q)
            IDLE: begin
                if (start && cmd_is_legal(cmd_op)) begin
                    op_d                 = cmd_op;
                    word_cnt_d           = (cmd_op == CMD_FAST) ? '0 : len;
                    bit_cnt_d            = '0;
                    cmd_phase_d          = 1'b1;
                    tx_d                 = '0;
                    tx_d[REG_W-1 -: 8]   = {cmd_op, cmd_arg};
                    state_d              = SETUP;
                end
            end
            SETUP, SHIFT_LO: begin
                if (tick) begin
                    state_d = SHIFT_HI;
                end
            end
            SHIFT_HI: begin
                if (tick) begin
                    rx_d = rx_word;
                    tx_d = {tx_q[REG_W-2:0], 1'b0};
                    if (!last_bit) begin
                        bit_cnt_d = bit_cnt_q + BIT_W'(1);
                        state_d   = SHIFT_LO;
                    end else begin
                        bit_cnt_d   = '0;
                        cmd_phase_d = 1'b0;
                        if (!cmd_phase_q && op_q == CMD_RD) begin
                            rd_data_d = rx_word;
                            rd_vld_d  = 1'b1;
                        end
                        if (word_cnt_q == '0) begin
                            tx_d    = '0;
                            state_d = HOLD;
                        end else begin
                            word_cnt_d = word_cnt_q - LEN_W'(1);
                            if (op_q == CMD_RD) begin
                                tx_d    = '0;
                                state_d = SHIFT_LO;
                            end else if (wr_valid) begin
                                tx_d       = wr_data;
                                wr_ready_d = 1'b1;
                                state_d    = SHIFT_LO;
                            end else begin
                                state_d = WAIT_WR;
                            end
                        end
                    end
                end
            end
            WAIT_WR: begin
                if (wr_valid) begin
                    tx_d       = wr_data;
                    wr_ready_d = 1'b1;
                    state_d    = SHIFT_LO;
                end
            end
            HOLD: begin
                if (tick) begin
                    gap_half_d = 1'b0;
                    state_d    = GAP;
                end
            end
            GAP: begin
                if (tick) begin
                    if (!gap_half_q) begin
                        gap_half_d = 1'b1;
                    end else begin
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        sclk_d = (state_d == SHIFT_HI);
        nss_d  = (state_d == IDLE) || (state_d == GAP);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            op_q        <= CMD_RD;
            word_cnt_q  <= '0;
            bit_cnt_q   <= '0;
            cmd_phase_q <= 1'b0;
            gap_half_q  <= 1'b0;
            tx_q        <= '0;
            rx_q        <= '0;
            rd_data_q   <= '0;
            rd_vld_q    <= 1'b0;
            wr_ready_q  <= 1'b0;
            done_q      <= 1'b0;
            sclk_q      <= 1'b0;
            nss_q       <= 1'b1;
            miso_s1_q   <= 1'b0;
            miso_s2_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            word_cnt_q  <= word_cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            cmd_phase_q <= cmd_phase_d;
            gap_half_q  <= gap_half_d;
            tx_q        <= tx_d;
            rx_q        <= rx_d;
            rd_data_q   <= rd_data_d;
            rd_vld_q    <= rd_vld_d;
            wr_ready_q  <= wr_ready_d;
            done_q      <= done_d;
            sclk_q      <= sclk_d;
            nss_q       <= nss_d;
            miso_s1_q   <= miso_s1_d;
            miso_s2_q   <= miso_s2_d;
        end
    end

`ifdef SPI_REG_MASTER_STATUS_EN
    logic [7:0] status_q, status_d;
    logic       status_vld_q, status_vld_d;

    always_comb begin
        status_d     = status_q;
        status_vld_d = 1'b0;
        if (state_q == SHIFT_HI && tick && last_bit && cmd_phase_q) begin
            status_d     = rx_word[7:0];
            status_vld_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            status_q     <= '0;
            status_vld_q <= 1'b0;
        end else begin
            status_q     <= status_d;
            status_vld_q <= status_vld_d;
        end
    end

    assign status     = status_q;
    assign status_vld = status_vld_q;
`else
    assign status     = 8'h00;
    assign status_vld = 1'b0;
`endif

    assign busy     = (state_q != IDLE);
    assign done     = done_q;
    assign wr_ready = wr_ready_q;
    assign rd_data  = rd_data_q;
    assign rd_vld   = rd_vld_q;
    assign sclk     = sclk_q;
    assign nss      = nss_q;
    assign mosi     = tx_q[REG_W-1];

endmodule

// File: tb/tb_spi_reg_master.sv
// Directed bench for spi_reg_master with a behavioural mode-0 register slave.
`define CHK(TAG, OBS, EXP) \
    begin \
        compared++; \
        assert ((OBS) === (EXP)) else begin \
            mismatched++; \
            $error("FAIL %s: observed %0h expected %0h", TAG, (OBS), (EXP)); \
        end \
    end

module tb_spi_reg_master;

    localparam int REG_W   = 8;
    localparam int CLK_DIV = 4;
    localparam int LEN_W   = 4;
    localparam logic [7:0] SLV_STATUS = 8'h5A;
`ifdef SPI_REG_MASTER_STATUS_EN
    localparam logic [7:0] EXP_STATUS = 8'h5A;
    localparam int         EXP_STV    = 1;
`else
    localparam logic [7:0] EXP_STATUS = 8'h00;
    localparam int         EXP_STV    = 0;
`endif

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [1:0]       cmd_op;
    logic [5:0]       cmd_arg;
    logic [LEN_W-1:0] len;
    logic             busy, done;
    logic [REG_W-1:0] wr_data;
    logic             wr_valid, wr_ready;
    logic [REG_W-1:0] rd_data;
    logic             rd_vld;
    logic [7:0]       status;
    logic             status_vld;
    logic             sclk, mosi, miso, nss;

    int compared   = 0;
    int mismatched = 0;

    spi_reg_master #(
        .REG_W   (REG_W),
        .CLK_DIV (CLK_DIV),
        .LEN_W   (LEN_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .cmd_op     (cmd_op),
        .cmd_arg    (cmd_arg),
        .len        (len),
        .busy       (busy),
        .done       (done),
        .wr_data    (wr_data),
        .wr_valid   (wr_valid),
        .wr_ready   (wr_ready),
        .rd_data    (rd_data),
        .rd_vld     (rd_vld),
        .status     (status),
        .status_vld (status_vld),
        .sclk       (sclk),
        .mosi       (mosi),
        .miso       (miso),
        .nss        (nss)
    );

    always #5 clk = ~clk;

    // Pulse monitors
    int         done_cnt = 0, wrr_cnt = 0, rdv_cnt = 0, stv_cnt = 0, edge_cnt = 0;
    logic [7:0] rd_log [0:63];

    always @(negedge clk) begin
        if (done === 1'b1) done_cnt++;
        if (wr_ready === 1'b1) wrr_cnt++;
        if (status_vld === 1'b1) stv_cnt++;
        if (rd_vld === 1'b1) begin
            rd_log[rdv_cnt[5:0]] = rd_data;
            rdv_cnt++;
        end
    end

    always @(posedge sclk) edge_cnt++;

    // Mode-0 slave: byte 0 is the command, then data bytes at auto-incrementing addresses
    logic [7:0] sregs    [0:63];
    logic [7:0] mosi_log [0:63];
    int         mosi_cnt;

    initial begin : slave
        logic [7:0] in_sr, out_sr, cmd;
        logic [5:0] addr;
        int         bit_i, byte_i;
        logic       active, sclk_prev, reload;
        for (int i = 0; i < 64; i++) sregs[i] = 8'h00;
        sregs[1] = 8'h11;
        sregs[2] = 8'h22;
        sregs[3] = 8'h33;
        mosi_cnt = 0;
        miso = 1'b0;
        active = 1'b0;
        in_sr = 8'h00; out_sr = 8'h00; cmd = 8'h00; addr = 6'd0;
        bit_i = 0; byte_i = 0; sclk_prev = 1'b0; reload = 1'b0;
        forever begin
            @(nss or sclk);
            if (nss !== 1'b0) begin
                active = 1'b0;
                miso = 1'b0;
            end else if (!active) begin
                active = 1'b1;
                bit_i = 0; byte_i = 0; reload = 1'b0;
                out_sr = SLV_STATUS;
                miso = out_sr[7];
                sclk_prev = sclk;
            end else begin
                if (sclk && !sclk_prev) begin
                    in_sr = {in_sr[6:0], mosi};
                    bit_i++;
                    if (bit_i == 8) begin
                        bit_i = 0;
                        mosi_log[mosi_cnt[5:0]] = in_sr;
                        mosi_cnt++;
                        if (byte_i == 0) begin
                            cmd = in_sr;
                            addr = in_sr[5:0];
                        end else begin
                            if (cmd[7:6] == 2'b10) sregs[addr] = in_sr;
                            addr = addr + 6'd1;
                        end
                        byte_i++;
                        out_sr = (cmd[7:6] == 2'b00) ? sregs[addr] : 8'hFF;
                        reload = 1'b1;
                    end
                end else if (!sclk && sclk_prev) begin
                    if (reload) reload = 1'b0;
                    else out_sr = {out_sr[6:0], 1'b0};
                    miso = out_sr[7];
                end
                sclk_prev = sclk;
            end
        end
    end

    function automatic logic [7:0] mlog(input int i);
        return mosi_log[i[5:0]];
    endfunction

    function automatic logic [7:0] rlog(input int i);
        return rd_log[i[5:0]];
    endfunction

    task automatic go(input logic [1:0] op, input logic [5:0] arg, input logic [LEN_W-1:0] n);
        @(negedge clk);
        cmd_op = op; cmd_arg = arg; len = n; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int k = 0;
        while (done !== 1'b1 && k < 2000) begin
            @(negedge clk);
            k++;
        end
        `CHK(tag, done, 1'b1)
        `CHK("busy drops with done", busy, 1'b0)
        @(negedge clk);
        `CHK("done single cycle", done, 1'b0)
        `CHK("nss idle after frame", nss, 1'b1)
    endtask

    task automatic wait_wr_ready(input string tag);
        int k = 0;
        while (wr_ready !== 1'b1 && k < 1000) begin
            @(negedge clk);
            k++;
        end
        `CHK(tag, wr_ready, 1'b1)
        @(negedge clk);
    endtask

    task automatic wait_edges(input string tag, input int target);
        int k = 0;
        while (edge_cnt < target && k < 1000) begin
            @(negedge clk);
            k++;
        end
        `CHK(tag, edge_cnt >= target, 1'b1)
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int d0, e0, m0, w0, r0, s0, e1, bad;
        rst = 1'b1; start = 1'b0; cmd_op = 2'b00; cmd_arg = 6'd0; len = '0;
        wr_data = 8'h00; wr_valid = 1'b0;
        repeat (3) @(negedge clk);
        `CHK("reset sclk", sclk, 1'b0)
        `CHK("reset nss", nss, 1'b1)
        `CHK("reset mosi", mosi, 1'b0)
        `CHK("reset busy", busy, 1'b0)
        `CHK("reset done", done, 1'b0)
        `CHK("reset wr_ready", wr_ready, 1'b0)
        `CHK("reset rd_vld", rd_vld, 1'b0)
        `CHK("reset status_vld", status_vld, 1'b0)
        `CHK("reset rd_data", rd_data, 8'h00)
        `CHK("reset status", status, 8'h00)
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Fastcmd 0x05 with a nonzero len that must be ignored
        d0 = done_cnt; e0 = edge_cnt; m0 = mosi_cnt; s0 = stv_cnt;
        go(2'b11, 6'h05, 4'd3);
        `CHK("fast busy", busy, 1'b1)
        `CHK("fast nss low", nss, 1'b0)
        `CHK("fast first bit", mosi, 1'b1)
        wait_done("fast done");
        `CHK("fast done count", done_cnt - d0, 1)
        `CHK("fast edges", edge_cnt - e0, 8)
        `CHK("fast byte count", mosi_cnt - m0, 1)
        `CHK("fast cmd byte", mlog(m0), 8'hC5)
        `CHK("fast status", status, EXP_STATUS)
        `CHK("fast status_vld count", stv_cnt - s0, EXP_STV)

        // Write burst A5, 3C to register 2
        d0 = done_cnt; e0 = edge_cnt; m0 = mosi_cnt; w0 = wrr_cnt; r0 = rdv_cnt;
        wr_data = 8'hA5; wr_valid = 1'b1;
        go(2'b10, 6'd2, 4'd2);
        wait_wr_ready("wr word1 ready");
        wr_data = 8'h3C;
        wait_wr_ready("wr word2 ready");
        wr_valid = 1'b0;
        wait_done("wr done");
        `CHK("wr ready count", wrr_cnt - w0, 2)
        `CHK("wr edges", edge_cnt - e0, 24)
        `CHK("wr cmd byte", mlog(m0), 8'h82)
        `CHK("wr byte1", mlog(m0 + 1), 8'hA5)
        `CHK("wr byte2", mlog(m0 + 2), 8'h3C)
        `CHK("wr slave reg2", sregs[2], 8'hA5)
        `CHK("wr slave reg3", sregs[3], 8'h3C)
        `CHK("wr no rd_vld", rdv_cnt - r0, 0)
        `CHK("wr done count", done_cnt - d0, 1)

        // Restore slave registers, then read 3 words from register 1
        sregs[2] = 8'h22; sregs[3] = 8'h33;
        m0 = mosi_cnt; r0 = rdv_cnt; s0 = stv_cnt; e0 = edge_cnt;
        go(2'b00, 6'd1, 4'd3);
        wait_done("rd done");
        `CHK("rd vld count", rdv_cnt - r0, 3)
        `CHK("rd word1", rlog(r0), 8'h11)
        `CHK("rd word2", rlog(r0 + 1), 8'h22)
        `CHK("rd word3", rlog(r0 + 2), 8'h33)
        `CHK("rd last data", rd_data, 8'h33)
        `CHK("rd status", status, EXP_STATUS)
        `CHK("rd status_vld count", stv_cnt - s0, EXP_STV)
        `CHK("rd cmd byte", mlog(m0), 8'h01)
        `CHK("rd mosi zero", mlog(m0 + 1), 8'h00)
        `CHK("rd edges", edge_cnt - e0, 32)

        // Write with a stall before word 2
        d0 = done_cnt; e0 = edge_cnt; m0 = mosi_cnt; w0 = wrr_cnt;
        wr_data = 8'h96; wr_valid = 1'b1;
        go(2'b10, 6'd8, 4'd2);
        wait_wr_ready("stall word1 ready");
        wr_valid = 1'b0; wr_data = 8'h0F;
        wait_edges("stall word1 edges", e0 + 16);
        repeat (6) @(negedge clk);
        e1 = edge_cnt; bad = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (sclk !== 1'b0 || nss !== 1'b0) bad++;
        end
        `CHK("stall sclk/nss low", bad, 0)
        `CHK("stall no edges", edge_cnt - e1, 0)
        `CHK("stall one ready so far", wrr_cnt - w0, 1)
        wr_valid = 1'b1;
        wait_wr_ready("stall word2 ready");
        wr_valid = 1'b0;
        wait_done("stall done");
        `CHK("stall edges", edge_cnt - e0, 24)
        `CHK("stall cmd byte", mlog(m0), 8'h88)
        `CHK("stall byte1", mlog(m0 + 1), 8'h96)
        `CHK("stall byte2", mlog(m0 + 2), 8'h0F)
        `CHK("stall slave reg8", sregs[8], 8'h96)
        `CHK("stall slave reg9", sregs[9], 8'h0F)

        // Reserved op is ignored
        d0 = done_cnt;
        go(2'b01, 6'd3, 4'd1);
        `CHK("illegal busy", busy, 1'b0)
        `CHK("illegal nss", nss, 1'b1)
        repeat (4) @(negedge clk);
        `CHK("illegal busy later", busy, 1'b0)
        `CHK("illegal no done", done_cnt - d0, 0)

        // Reset in the middle of a read frame
        d0 = done_cnt; e0 = edge_cnt;
        go(2'b00, 6'd1, 4'd1);
        wait_edges("midrst bit4", e0 + 4);
        @(posedge clk);
        #2;
        `CHK("midrst sclk high before", sclk, 1'b1)
        rst = 1'b1;
        #1;
        `CHK("midrst nss", nss, 1'b1)
        `CHK("midrst sclk", sclk, 1'b0)
        `CHK("midrst busy", busy, 1'b0)
        `CHK("midrst rd_data", rd_data, 8'h00)
        repeat (3) @(negedge clk);
        rst = 1'b0;
        `CHK("midrst no done", done_cnt - d0, 0)

        // Next transaction after reset
        d0 = done_cnt; e0 = edge_cnt; m0 = mosi_cnt;
        go(2'b11, 6'h2A, 4'd0);
        wait_done("post-rst done");
        `CHK("post-rst cmd byte", mlog(m0), 8'hEA)
        `CHK("post-rst edges", edge_cnt - e0, 8)
        `CHK("post-rst done count", done_cnt - d0, 1)

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
